// File: rtl/mips_pkg.sv
// Shared ALU operation encodings for the EX stage and its combinational core.
package mips_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_AND = 3'b000;
    localparam alu_op_t ALU_OR  = 3'b001;
    localparam alu_op_t ALU_ADD = 3'b010;
    localparam alu_op_t ALU_SUB = 3'b110;
    localparam alu_op_t ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: executes one operation code and flags illegal codes and
// signed overflow on ADD/SUB.
module alu_core
    import mips_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  alu_op_t        op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   result,
    output logic           illegal,
    output logic           ovf
);

    logic [W-1:0] w_sum;
    logic [W-1:0] w_diff;

    assign w_sum  = a + b;
    assign w_diff = a - b;

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        ovf     = 1'b0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: begin
                result = w_sum;
                ovf    = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                result = w_diff;
                // subtraction overflows when a and ~b share a sign the result lacks
                ovf    = (a[W-1] != b[W-1]) && (w_diff[W-1] != a[W-1]);
            end
            ALU_SLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// EX pipeline stage: one-entry valid/ready slot holding the ALU result for MEM.
// Define OVF_TRAP_EN to add out_ovf and suppress regwrite on signed ADD/SUB overflow.
module alu_exec_stage
    import mips_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [4:0]       in_rd,
    input  logic             in_regwrite,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic             out_zero,
    output logic [4:0]       out_rd,
    output logic             out_regwrite,
    output logic             out_illegal,
`ifdef OVF_TRAP_EN
    output logic             out_ovf,
`endif
    output logic [CNT_W-1:0] stall_cnt
);

`ifdef OVF_TRAP_EN
    localparam bit OVF_TRAP = 1'b1;
`else
    localparam bit OVF_TRAP = 1'b0;
`endif

    logic [W-1:0]     w_result;
    logic             w_illegal;
    logic             w_ovf;
    logic             w_accept;
    logic             w_stall;
    logic             w_regwrite;

    logic             r_valid;
    logic [W-1:0]     r_result;
    logic [4:0]       r_rd;
    logic             r_regwrite;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    alu_core #(.W(W)) u_alu_core (
        .op      (in_op),
        .a       (in_a),
        .b       (in_b),
        .result  (w_result),
        .illegal (w_illegal),
        .ovf     (w_ovf)
    );

    assign in_ready   = !reset && (!r_valid || out_ready);
    assign w_accept   = in_valid && in_ready && !flush;
    assign w_stall    = r_valid && !out_ready && !flush;
    assign w_regwrite = in_regwrite && !w_illegal && !(OVF_TRAP && w_ovf);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_illegal  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_stall && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // flush wins over both accept and hold; payload is left untouched
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid    <= 1'b1;
                r_result   <= w_result;
                r_rd       <= in_rd;
                r_regwrite <= w_regwrite;
                r_illegal  <= w_illegal;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef OVF_TRAP_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= w_ovf;
        end
    end

    assign out_ovf = r_ovf;
`endif

    assign out_valid    = r_valid;
    assign out_result   = r_result;
    assign out_zero     = (r_result == '0);
    assign out_rd       = r_rd;
    assign out_regwrite = r_regwrite;
    assign out_illegal  = r_illegal;
    assign stall_cnt    = r_cnt;

endmodule
